// File: rtl/pzcorebus_local_id_allocator.sv
// Local-ID allocator: free/busy bitmap that hands out the lowest free ID to
// each new non-posted command and frees it on the last response beat.
module pzcorebus_local_id_allocator #(
  parameter  int unsigned LOCAL_ID_WIDTH = 4,
  parameter  int unsigned NUM_IDS        = 16,
  localparam int unsigned COUNT_WIDTH    = $clog2(NUM_IDS + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_stop,
  input  logic                      i_alloc_valid,
  output logic                      o_alloc_ready,
  output logic [LOCAL_ID_WIDTH-1:0] o_alloc_id,
  input  logic                      i_release_valid,
  input  logic [LOCAL_ID_WIDTH-1:0] i_release_id,
  output logic [NUM_IDS-1:0]        o_busy,
  output logic [COUNT_WIDTH-1:0]    o_outstanding,
  output logic                      o_full,
  output logic                      o_idle,
  output logic                      o_release_error
);

  logic [NUM_IDS-1:0]        r_busy;
  logic [COUNT_WIDTH-1:0]    r_outstanding;
  logic                      r_full;
  logic                      r_idle;
  logic                      r_release_error;

  logic [LOCAL_ID_WIDTH-1:0] w_alloc_id;
  logic [NUM_IDS-1:0]        w_alloc_mask;
  logic [NUM_IDS-1:0]        w_release_mask;
  logic                      w_alloc;
  logic                      w_release_ok;
  logic                      w_release_bad;
  logic [NUM_IDS-1:0]        w_busy_next;
  logic [COUNT_WIDTH-1:0]    w_outstanding_next;

  // Lowest free ID: scan from the top so the smallest free index wins.
  always_comb begin
    w_alloc_id = '0;
    for (int i = int'(NUM_IDS) - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_alloc_id = LOCAL_ID_WIDTH'(i);
      end
    end
  end

  // Ready depends only on the registered bitmap state and the stop request.
  assign o_alloc_ready = !i_stop && !r_full;
  assign o_alloc_id    = w_alloc_id;
  assign w_alloc       = i_alloc_valid && o_alloc_ready;

  // One-hot decodes; an out-of-range release ID matches no bit.
  always_comb begin
    w_alloc_mask   = '0;
    w_release_mask = '0;
    for (int i = 0; i < int'(NUM_IDS); i++) begin
      w_alloc_mask[i]   = (w_alloc_id == LOCAL_ID_WIDTH'(i));
      w_release_mask[i] = (i_release_id == LOCAL_ID_WIDTH'(i));
    end
  end

  assign w_release_ok  = i_release_valid && (|(w_release_mask & r_busy));
  assign w_release_bad = i_release_valid && !w_release_ok;

  // Next bitmap and counter; same-cycle alloc/release always hit different IDs.
  always_comb begin
    w_busy_next = r_busy;
    if (w_alloc) begin
      w_busy_next = w_busy_next | w_alloc_mask;
    end
    if (w_release_ok) begin
      w_busy_next = w_busy_next & ~w_release_mask;
    end
    w_outstanding_next = r_outstanding;
    case ({w_alloc, w_release_ok})
      2'b10:   w_outstanding_next = r_outstanding + COUNT_WIDTH'(1);
      2'b01:   w_outstanding_next = r_outstanding - COUNT_WIDTH'(1);
      default: w_outstanding_next = r_outstanding;
    endcase
  end

  // State registers; flags are precomputed from the next counter value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy          <= '0;
      r_outstanding   <= '0;
      r_full          <= 1'b0;
      r_idle          <= 1'b1;
      r_release_error <= 1'b0;
    end else begin
      r_busy        <= w_busy_next;
      r_outstanding <= w_outstanding_next;
      r_full        <= (w_outstanding_next == COUNT_WIDTH'(NUM_IDS));
      r_idle        <= (w_outstanding_next == '0);
      if (w_release_bad) begin
        r_release_error <= 1'b1;
      end
    end
  end

  assign o_busy          = r_busy;
  assign o_outstanding   = r_outstanding;
  assign o_full          = r_full;
  assign o_idle          = r_idle;
  assign o_release_error = r_release_error;

  // Allocation is never granted while every ID is busy.
  a_no_alloc_when_full: assert property (
    @(posedge i_clk) disable iff (!i_rst_n) !(w_alloc && r_full)
  );

  // The counter always mirrors the number of busy bits.
  a_count_matches_bitmap: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    r_outstanding == COUNT_WIDTH'($countones(r_busy))
  );

endmodule

// File: tb/tb_pzcorebus_local_id_allocator.sv
// Scoreboard bench for pzcorebus_local_id_allocator (LOCAL_ID_WIDTH=5, NUM_IDS=16).
module tb_pzcorebus_local_id_allocator;

  localparam int unsigned W  = 5;
  localparam int unsigned N  = 16;
  localparam int unsigned CW = 5;

  typedef struct packed {
    logic [N-1:0]  busy;
    logic [CW-1:0] outs;
    logic          ready;
    logic [W-1:0]  id;
    logic          err;
  } stat_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          stop  = 1'b0;
  logic          av    = 1'b0;
  logic          rv    = 1'b0;
  logic [W-1:0]  rid   = '0;
  logic          chk   = 1'b0;

  logic          w_ready;
  logic [W-1:0]  w_id;
  logic [N-1:0]  w_busy;
  logic [CW-1:0] w_outs;
  logic          w_full;
  logic          w_idle;
  logic          w_err;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] alloc_q[$];
  stat_t        stat_q[$];
  logic [W-1:0] mon_id;
  stat_t        mon_s;

  pzcorebus_local_id_allocator #(
    .LOCAL_ID_WIDTH(W),
    .NUM_IDS       (N)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_stop         (stop),
    .i_alloc_valid  (av),
    .o_alloc_ready  (w_ready),
    .o_alloc_id     (w_id),
    .i_release_valid(rv),
    .i_release_id   (rid),
    .o_busy         (w_busy),
    .o_outstanding  (w_outs),
    .o_full         (w_full),
    .o_idle         (w_idle),
    .o_release_error(w_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1);
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever a grant happens or a status check is requested.
  always @(negedge clk) begin
    if (rst_n && av && w_ready) begin
      if (alloc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: got id 0x%0h expected no grant at %0t", w_id, $time);
      end else begin
        mon_id = alloc_q.pop_front();
        cmp("alloc_id", int'(w_id), int'(mon_id));
      end
    end
    if (chk) begin
      if (stat_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stat_queue: got empty queue expected an entry at %0t", $time);
      end else begin
        mon_s = stat_q.pop_front();
        cmp("busy",        int'(w_busy),  int'(mon_s.busy));
        cmp("outstanding", int'(w_outs),  int'(mon_s.outs));
        cmp("alloc_ready", int'(w_ready), int'(mon_s.ready));
        cmp("alloc_id_st", int'(w_id),    int'(mon_s.id));
        cmp("release_err", int'(w_err),   int'(mon_s.err));
        cmp("full",        int'(w_full),  (mon_s.outs == CW'(N)) ? 1 : 0);
        cmp("idle",        int'(w_idle),  (mon_s.outs == '0) ? 1 : 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    chk = 1'b0;
  endtask

  // Queue a status expectation checked at this cycle's falling edge.
  task automatic expect_stat(input logic [N-1:0] b, input int o, input logic r,
                             input int id, input logic e);
    stat_t s;
    s.busy  = b;
    s.outs  = CW'(o);
    s.ready = r;
    s.id    = W'(id);
    s.err   = e;
    stat_q.push_back(s);
    chk = 1'b1;
    step();
  endtask

  task automatic alloc_n(input int n, input int first);
    for (int k = 0; k < n; k++) begin
      av = 1'b1;
      alloc_q.push_back(W'(first + k));
      step();
    end
    av = 1'b0;
  endtask

  task automatic release1(input int id);
    rv  = 1'b1;
    rid = W'(id);
    step();
    rv  = 1'b0;
  endtask

  task automatic do_reset();
    av    = 1'b0;
    rv    = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    step();
    step();
    rst_n = 1'b1;
    expect_stat(16'h0000, 0, 1'b1, 0, 1'b0);

    // Three allocations hand out 0,1,2.
    alloc_n(3, 0);
    expect_stat(16'h0007, 3, 1'b1, 3, 1'b0);

    // Fill up, then confirm back-pressure with a request pending.
    alloc_n(13, 3);
    av = 1'b1;
    expect_stat(16'hFFFF, 16, 1'b0, 0, 1'b0);
    av = 1'b0;

    // Release 5 while full: allocatable next cycle.
    release1(5);
    expect_stat(16'hFFDF, 15, 1'b1, 5, 1'b0);
    alloc_n(1, 5);
    expect_stat(16'hFFFF, 16, 1'b0, 0, 1'b0);

    // Drain down to IDs 0..3.
    for (int i = 4; i < 16; i++) begin
      release1(i);
    end
    expect_stat(16'h000F, 4, 1'b1, 4, 1'b0);

    // Same-cycle alloc and release of ID 1.
    av  = 1'b1;
    rv  = 1'b1;
    rid = W'(1);
    alloc_q.push_back(W'(4));
    step();
    av = 1'b0;
    rv = 1'b0;
    expect_stat(16'h001D, 4, 1'b1, 1, 1'b0);

    // Out-of-range release.
    do_reset();
    alloc_n(2, 0);
    release1(20);
    expect_stat(16'h0003, 2, 1'b1, 2, 1'b1);

    // Release of a non-busy ID; error stays sticky across allocations.
    do_reset();
    expect_stat(16'h0000, 0, 1'b1, 0, 1'b0);
    alloc_n(2, 0);
    release1(7);
    expect_stat(16'h0003, 2, 1'b1, 2, 1'b1);
    alloc_n(2, 2);
    expect_stat(16'h000F, 4, 1'b1, 4, 1'b1);

    // Stop/drain.
    do_reset();
    alloc_n(2, 0);
    stop = 1'b1;
    av   = 1'b1;
    expect_stat(16'h0003, 2, 1'b0, 2, 1'b0);
    av = 1'b0;
    release1(0);
    expect_stat(16'h0002, 1, 1'b0, 0, 1'b0);
    release1(1);
    expect_stat(16'h0000, 0, 1'b0, 0, 1'b0);
    stop = 1'b0;
    expect_stat(16'h0000, 0, 1'b1, 0, 1'b0);
    alloc_n(1, 0);
    expect_stat(16'h0001, 1, 1'b1, 1, 1'b0);

    // Asynchronous reset mid-traffic with 9 busy.
    do_reset();
    alloc_n(9, 0);
    expect_stat(16'h01FF, 9, 1'b1, 9, 1'b0);
    rst_n = 1'b0;
    expect_stat(16'h0000, 0, 1'b1, 0, 1'b0);
    rst_n = 1'b1;
    step();
    step();

    cmp("alloc_q_empty", alloc_q.size(), 0);
    cmp("stat_q_empty",  stat_q.size(),  0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
